// File: rtl/vxc_axpy_sequencer_if.sv
// Handshake/bus bundle for vxc_axpy_sequencer.
// The master side issues jobs (start/op_in/abort). The slave side is the sequencer, which drives
// the job status, the operand read strobe, the datapath controls and the result write strobe.
// Signals:
//   start, op_in, abort           job request, op select (0 add / 1 sub), synchronous cancel
//   busy, done, perf_cycles       job status, completion pulse, cycle count of last job
//   rd_en, rd_addr                chunk read strobe and chunk index (1-cycle read latency)
//   dp_op, dp_valid               datapath op and operand-valid
//   wr_en, wr_addr, wr_mask       result chunk write strobe, chunk index, per-lane enables
// NI and AW must match the parameters of the sequencer bound to this interface.
interface vxc_axpy_sequencer_if #(
   parameter int unsigned NI = 8,
   parameter int unsigned AW = 8
);
   logic          start;
   logic          op_in;
   logic          abort;
   logic          busy;
   logic          done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          dp_op;
   logic          dp_valid;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [NI-1:0] wr_mask;
   logic [15:0]   perf_cycles;

   modport master (
      output start, op_in, abort,
      input  busy, done, rd_en, rd_addr, dp_op, dp_valid, wr_en, wr_addr, wr_mask, perf_cycles
   );

   modport slave (
      input  start, op_in, abort,
      output busy, done, rd_en, rd_addr, dp_op, dp_valid, wr_en, wr_addr, wr_mask, perf_cycles
   );
endinterface

// File: rtl/vxc_axpy_sequencer.sv
// Chunked vector add/subtract job sequencer.
// A job walks C = ceil(NOE/NI) chunks: it reads one chunk per cycle from the operand memories,
// marks operands valid one cycle later, and writes each result chunk 1+PIPE_LAT cycles after its
// read. The last chunk's write mask covers only the lanes that hold real elements.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (release is synchronised before a job may start)
//   bus    vxc_axpy_sequencer_if slave modport (see the interface for the signal list)
// Optional feature: define VXC_SEQ_PERF_CNT_EN to build the saturating 16-bit job cycle counter
// that drives perf_cycles; otherwise perf_cycles is tied to 0.
module vxc_axpy_sequencer #(
   parameter int unsigned NOE      = 19,
   parameter int unsigned NI       = 8,
   parameter int unsigned PIPE_LAT = 8,
   parameter int unsigned AW       = 8
) (
   input logic                 clk,
   input logic                 reset,
   vxc_axpy_sequencer_if.slave bus
);

   localparam int unsigned   NumChunks = (NOE + NI - 1) / NI;
   localparam int unsigned   LastLanes = NOE - (NumChunks - 1) * NI;
   localparam logic [AW-1:0] LastAddr  = AW'(NumChunks - 1);

   function automatic logic [NI-1:0] lane_mask(input int unsigned lanes);
      logic [NI-1:0] m;
      m = '0;
      for (int unsigned j = 0; j < NI; j++) begin
         if (j < lanes) m[j] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [NI-1:0] LastMask = lane_mask(LastLanes);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e            state_q;
   logic              busy_q;
   logic              done_q;
   logic              rd_en_q;
   logic [AW-1:0]     rd_addr_q;
   logic              dp_op_q;
   logic [1:0]        arm_q;
   logic [PIPE_LAT:0] vld_q;
   logic [AW-1:0]     addr_q [PIPE_LAT+1];

   logic              accept;
   logic              kill;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic              last_wr;
   logic [NI-1:0]     wr_mask;

   // arm_q[1] rises on the second edge after reset release; no job is accepted before that.
   assign accept  = (state_q == StIdle) && bus.start && arm_q[1];
   assign kill    = bus.abort && ((state_q == StIssue) || (state_q == StDrain));
   assign wr_en   = vld_q[PIPE_LAT];
   assign wr_addr = addr_q[PIPE_LAT];
   assign last_wr = wr_en && (wr_addr == LastAddr);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         dp_op_q   <= 1'b0;
         arm_q     <= '0;
      end else begin
         arm_q  <= {arm_q[0], 1'b1};
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q   <= StIssue;
                  busy_q    <= 1'b1;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= '0;
                  dp_op_q   <= bus.op_in;
               end
            end
            StIssue: begin
               if (kill) begin
                  state_q   <= StIdle;
                  busy_q    <= 1'b0;
                  rd_en_q   <= 1'b0;
                  rd_addr_q <= '0;
               end else if (rd_addr_q == LastAddr) begin
                  state_q   <= StDrain;
                  rd_en_q   <= 1'b0;
                  rd_addr_q <= '0;
               end else begin
                  rd_addr_q <= rd_addr_q + AW'(1);
               end
            end
            StDrain: begin
               if (kill) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (last_wr) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Stage 0 is the operand-valid slot; stage PIPE_LAT lines up with the datapath result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_q <= '0;
         for (int unsigned k = 0; k <= PIPE_LAT; k++) addr_q[k] <= '0;
      end else if (kill) begin
         vld_q <= '0;
         for (int unsigned k = 0; k <= PIPE_LAT; k++) addr_q[k] <= '0;
      end else begin
         vld_q[0]  <= rd_en_q;
         addr_q[0] <= rd_addr_q;
         for (int unsigned k = 1; k <= PIPE_LAT; k++) begin
            vld_q[k]  <= vld_q[k-1];
            addr_q[k] <= addr_q[k-1];
         end
      end
   end

   always_comb begin
      wr_mask = '0;
      if (wr_en) wr_mask = (wr_addr == LastAddr) ? LastMask : '1;
   end

`ifdef VXC_SEQ_PERF_CNT_EN
   logic [15:0] cnt_q;
   logic [15:0] perf_q;

   // cnt_q counts the accept cycle as 1; the DONE cycle is folded in when perf_q loads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         perf_q <= '0;
      end else begin
         if (accept) begin
            cnt_q <= 16'd1;
         end else if ((state_q != StIdle) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
         end
         if (state_q == StDone) begin
            perf_q <= (cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1;
         end
      end
   end

   assign bus.perf_cycles = perf_q;
`else
   assign bus.perf_cycles = '0;
`endif

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.rd_en    = rd_en_q;
   assign bus.rd_addr  = rd_addr_q;
   assign bus.dp_op    = dp_op_q;
   assign bus.dp_valid = vld_q[0];
   assign bus.wr_en    = wr_en;
   assign bus.wr_addr  = wr_addr;
   assign bus.wr_mask  = wr_mask;

endmodule

// File: doc/vxc_axpy_sequencer.md
VXC_AXPY_SEQUENCER -- requirements
Module: vxc_axpy_sequencer

Interface
REQ-001 Parameter NOE, default 19: number of complex elements per vector job.
REQ-002 Parameter NI, default 8: lanes per chunk, equal to the multiplier/adder lane count.
REQ-003 Parameter PIPE_LAT, default 8: cycles from datapath input to valid `result`.
REQ-004 Parameter AW, default 8: chunk address width; ceil(NOE/NI) SHALL be at most 2^AW.
REQ-005 One clock and one reset; `reset` is asynchronous and active-low.
REQ-006 Port `clk`, input, 1: rising-edge clock.
REQ-007 Port `reset`, input, 1: asynchronous active-low reset.
REQ-008 Port `start`, input, 1: job request, sampled in IDLE.
REQ-009 Port `op_in`, input, 1: 0 = add, 1 = subtract, captured with `start`.
REQ-010 Port `abort`, input, 1: synchronous job cancel.
REQ-011 Port `busy`, output, 1: job in progress.
REQ-012 Port `done`, output, 1: one-cycle job-complete pulse.
REQ-013 Port `rd_en`, output, 1: chunk read strobe to the operand memories, with 1-cycle read latency.
REQ-014 Port `rd_addr`, output, AW: chunk index being read.
REQ-015 Port `dp_op`, output, 1: op to the adder/subtractor lanes.
REQ-016 Port `dp_valid`, output, 1: operands present at the datapath inputs this cycle.
REQ-017 Port `wr_en`, output, 1: result chunk write strobe.
REQ-018 Port `wr_addr`, output, AW: chunk index of the result.
REQ-019 Port `wr_mask`, output, NI: per-lane write enables; bit j covers element chunk*NI+j.
REQ-020 Port `perf_cycles`, output, 16: cycle count of the last completed job.

Function
REQ-021 Define C = ceil(NOE/NI); a job SHALL process exactly C chunks, with no padding chunk when NI divides NOE.
REQ-022 The FSM SHALL have four states: IDLE, ISSUE, DRAIN and DONE.
REQ-023 IDLE to ISSUE occurs when `start`=1; `op_in` is latched into `dp_op` and held for the whole job.
REQ-024 In ISSUE, `rd_en` SHALL be high every cycle with `rd_addr` = 0,1,...,C-1 on consecutive cycles; the FSM moves to DRAIN after chunk C-1 is issued.
REQ-025 `dp_valid` SHALL equal `rd_en` delayed by one cycle.
REQ-026 `wr_en` SHALL equal `rd_en` delayed by 1+PIPE_LAT cycles, with `wr_addr` carrying the matching chunk index through the same delay line.
REQ-027 `wr_mask` SHALL be all ones except on chunk C-1, where it is (1<<(NOE-(C-1)*NI))-1; it SHALL be zero whenever `wr_en`=0.
REQ-028 DRAIN to DONE occurs in the cycle after the last `wr_en`.
REQ-029 In DONE, `done`=1 and `busy`=0 for one cycle, then the FSM returns to IDLE.
REQ-030 `busy` SHALL be 1 in ISSUE and DRAIN only.
REQ-031 `start` while not in IDLE SHALL be ignored; it is neither queued nor latched.
REQ-032 `start` in the DONE cycle SHALL be ignored; a new job needs `start` in IDLE.
REQ-033 When `abort`=1 in ISSUE or DRAIN, the FSM SHALL go to IDLE next cycle and clear all delay-line valids; no further `rd_en`/`wr_en` and no `done` pulse follow.
REQ-034 `abort` in IDLE or DONE SHALL have no effect.
REQ-035 `abort` and `start` together in IDLE: `start` wins.
REQ-036 For the defaults, `start` accepted at cycle 0 gives `rd_en` in cycles 1-3, `wr_en` in cycles 10-12, and `done` in cycle 13.

Reset
REQ-037 While `reset`=0, the FSM SHALL be IDLE, all delay-line valids cleared, and `busy`, `done`, `rd_en`, `dp_valid`, `wr_en`, `wr_mask`, `rd_addr`, `wr_addr`, `dp_op` and `perf_cycles` all 0.
REQ-038 Reset assertion mid-job SHALL take effect immediately, with no `wr_en` or `done` afterwards until a new `start`.
REQ-039 Reset deassertion SHALL be synchronised so the FSM leaves IDLE no earlier than the second rising edge after release.

Configuration
REQ-040 Macro VXC_SEQ_PERF_CNT_EN defined: a 16-bit counter SHALL run from the `start`-accept cycle through the DONE cycle inclusive, saturate at 0xFFFF, and load `perf_cycles` at `done`; an aborted job SHALL leave `perf_cycles` unchanged.
REQ-041 Macro VXC_SEQ_PERF_CNT_EN undefined: `perf_cycles` SHALL be constant 0 and no counter logic is built.

Verification
REQ-042 Defaults, `start`=1 with `op_in`=1 for one cycle -> `rd_addr` 0,1,2 in cycles 1-3; `wr_mask` 0xFF, 0xFF, 0x07 in cycles 10-12; `dp_op`=1 throughout; `done` in cycle 13; `perf_cycles`=14 when the macro is defined.
REQ-043 NOE=16 -> C=2 with `wr_mask` 0xFF, 0xFF; NOE=5 -> C=1 with `wr_mask` 0x1F and `done` in cycle 11.
REQ-044 `start` pulsed in cycles 2 and 13 of a job -> both ignored; a second job starts only on `start` in cycle 14 or later.
REQ-045 `abort` in cycle 5 -> `busy`=0 from cycle 6, no `wr_en` in cycles 10-12, no `done`, `perf_cycles` unchanged.
REQ-046 `reset` dropped in cycle 11 -> all outputs 0 immediately, no `done`; after release plus 2 edges, a new `start` runs a normal job.
